// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin scheduler sharing one pipelined FP_ADD among NREQ requesters.
// Latency: transfer in cycle t -> add_a/add_b in t+1 -> one-cycle rsp_valid in t+LAT+2.
// Backpressure: one-hot req_ready grant only in RUN; responses have none. Optional FP_ADD_SCHED_STATS_EN adds stat counters.
module fp_add_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 7,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    input  logic [31:0]        add_q,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_data,
    input  logic               drain,
    output logic               idle
`ifdef FP_ADD_SCHED_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_conflict
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

    state_t          state_q;
    logic            idle_q;
    logic [IDW-1:0]  last_q;
    logic [31:0]     add_a_q;
    logic [31:0]     add_b_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [31:0]     rsp_data_q;

    // Tag pipeline: stage 0 is written at transfer, stage LAT lines up with add_q.
    logic [LAT:0]    sr_vld_q;
    logic [LAT:0]    sr_vld_d;
    logic [IDW-1:0]  sr_id_q [LAT+1];

    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic [IDW-1:0]  scan_idx;
    logic            xfer;
    logic            sr_empty;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_id   = last_q;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((int'(last_q) + k) % NREQ);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_idx;
            end
        end
    end

    // Grants are suppressed while reset is held and outside RUN.
    always_comb begin
        req_ready = '0;
        if (reset && (state_q == ST_RUN) && gnt_any) begin
            req_ready = NREQ'(1) << gnt_id;
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign sr_empty = ~|sr_vld_q;
    assign sr_vld_d = {sr_vld_q[LAT-1:0], xfer};

    // Run/drain/idle control; idle is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            idle_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (drain) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain) begin
                        state_q <= ST_RUN;
                    end else if (sr_empty) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!drain) begin
                        state_q <= ST_RUN;
                        idle_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers, arbitration pointer, tag valids and response register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            last_q      <= IDW'(NREQ - 1);
            sr_vld_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (xfer) begin
                add_a_q <= req_a[{gnt_id, 5'b0} +: 32];
                add_b_q <= req_b[{gnt_id, 5'b0} +: 32];
                last_q  <= gnt_id;
            end
            sr_vld_q <= sr_vld_d;
            if (sr_vld_q[LAT]) begin
                rsp_data_q  <= add_q;
                rsp_valid_q <= NREQ'(1) << sr_id_q[LAT];
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

    // Requester tags ride alongside the valids; their value only matters when valid.
    always_ff @(posedge clk) begin
        sr_id_q[0] <= gnt_id;
        for (int s = 1; s <= LAT; s++) begin
            sr_id_q[s] <= sr_id_q[s-1];
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign idle      = idle_q;

`ifdef FP_ADD_SCHED_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_conflict_q;
    logic        contended;

    assign contended = ($countones(req_valid) > 1) && (state_q == ST_RUN);

    // Saturating transfer and contention counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            if (xfer && (stat_issued_q != '1)) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (contended && (stat_conflict_q != '1)) begin
                stat_conflict_q <= stat_conflict_q + 32'd1;
            end
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// tb_fp_add_sched: randomized and directed stimulus for fp_add_sched with a queue scoreboard.
// Latency: expected responses are due LAT+2 cycles after each observed transfer.
// Backpressure: none on responses; grants are predicted each cycle from a round-robin model.
module tb_fp_add_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_q;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic               drain;
    logic               idle;
`ifdef FP_ADD_SCHED_STATS_EN
    logic [31:0]        stat_issued;
    logic [31:0]        stat_conflict;
`endif

    fp_add_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_q     (add_q),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .drain     (drain),
        .idle      (idle)
`ifdef FP_ADD_SCHED_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- float helpers (exact for integer-valued operands) ----------------
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] rnd_op();
        return r2f(real'(int'($urandom_range(0, 200000)) - 100000));
    endfunction

    // ---------------- shared adder model: LAT-cycle pipeline ----------------
    logic [31:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= r2f(f2r(add_a) + f2r(add_b));
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_q = apipe[LAT-1];

    // ---------------- check bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic fail_msg(input string nm, input int act, input int exp);
        n_chk++;
        $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model state ----------------
    typedef enum {M_RUN, M_DRAIN, M_IDLE} mst_t;
    typedef struct {int id; logic [31:0] dat; int cyc;} exp_t;
    typedef struct {logic [NREQ-1:0] vld; logic [31:0] dat;} rsp_t;

    mst_t        m_state = M_RUN;
    int          m_last  = NREQ - 1;
    logic [31:0] m_rsp   = 32'h0;
    exp_t        sb_q[$];
    int          grant_log[$];
    rsp_t        rsp_log[$];
    int          rsp_cnt  = 0;
    int          cyc      = 0;
    bit          armed    = 1'b0;
    bit          rst_chk  = 1'b0;
    bit          pend_chk = 1'b0;
    logic [31:0] pend_a, pend_b;
    int          m_iss    = 0;
    int          m_conf   = 0;

    function automatic int arb(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic mdl_reset();
        m_state  = M_RUN;
        m_last   = NREQ - 1;
        m_rsp    = 32'h0;
        sb_q.delete();
        pend_chk = 1'b0;
        rst_chk  = 1'b1;
        m_iss    = 0;
        m_conf   = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        cyc++;
        if (!armed) begin
            if (!reset) begin
                armed = 1'b1;
                mdl_reset();
            end
        end else begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                fail_msg("rsp_missing_due_cycle", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                rsp_log.push_back('{vld: rsp_valid, dat: rsp_data});
                if (sb_q.size() == 0) begin
                    fail_msg("rsp_unexpected_cycle", cyc, -1);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.id));
                    chk("rsp_data", rsp_data, e.dat);
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    m_rsp = e.dat;
                end
            end else begin
                chk("rsp_data_hold", rsp_data, m_rsp);
            end

            if (rst_chk) begin
                chk("reset_add_a", add_a, 32'h0);
                chk("reset_add_b", add_b, 32'h0);
                rst_chk = 1'b0;
            end else if (pend_chk) begin
                chk("add_a", add_a, pend_a);
                chk("add_b", add_b, pend_b);
            end
            pend_chk = 1'b0;

            g       = (reset && m_state == M_RUN) ? arb(req_valid, m_last) : -1;
            exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("idle", 32'(idle), 32'(m_state == M_IDLE));

            if (reset && m_state == M_RUN && $countones(req_valid) > 1) m_conf++;

            if (g >= 0) begin
                pend_a = req_a[32*g +: 32];
                pend_b = req_b[32*g +: 32];
                sb_q.push_back('{id: g, dat: r2f(f2r(pend_a) + f2r(pend_b)), cyc: cyc + LAT + 2});
                grant_log.push_back(g);
                m_last   = g;
                pend_chk = 1'b1;
                m_iss++;
            end

            if (!reset) begin
                mdl_reset();
            end else begin
                case (m_state)
                    M_RUN:   if (drain) m_state = M_DRAIN;
                    M_DRAIN: if (!drain) m_state = M_RUN;
                             else if (sb_q.size() == 0) m_state = M_IDLE;
                    M_IDLE:  if (!drain) m_state = M_RUN;
                    default: m_state = M_RUN;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n0;
        int r0;
        int drain_cnt;
        int dens;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        drain     = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (6) tick();

        // Single operation: 1.0 + 2.0 from requester 2.
        rsp_log.delete();
        set_req(2, 32'h3F80_0000, 32'h4000_0000);
        tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("single_rsp_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() == 1) begin
            chk("single_rsp_id", 32'(rsp_log[0].vld), 32'h4);
            chk("single_rsp_data", rsp_log[0].dat, 32'h4040_0000);
        end

        // Fairness: all requesters contend for 8 cycles straight after reset.
        pulse_reset();
        grant_log.delete();
        rsp_log.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op());
        repeat (8) tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("fair_grant_count", 32'(grant_log.size()), 32'd8);
        chk("fair_rsp_count", 32'(rsp_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            chk("fair_grant_order", 32'(grant_log[k]), 32'(k % NREQ));
        for (int k = 0; k < 8 && k < rsp_log.size(); k++)
            chk("fair_rsp_tag", 32'(rsp_log[k].vld), 32'(NREQ'(1) << (k % NREQ)));

        // Drain while requester 1 streams, then release.
        for (int c = 0; c < 6; c++) begin
            set_req(1, rnd_op(), rnd_op());
            tick();
        end
        drain = 1'b1;
        tick();
        n0 = grant_log.size();
        repeat (19) tick();
        chk("drain_no_grant", 32'(grant_log.size()), 32'(n0));
        chk("drain_idle", 32'(idle), 32'd1);
        drain = 1'b0;
        repeat (3) tick();
        req_valid = '0;
        repeat (LAT + 4) tick();

        // Reset with three operations in flight.
        for (int c = 0; c < 3; c++) begin
            set_req(0, rnd_op(), rnd_op());
            tick();
        end
        req_valid = '0;
        repeat (2) tick();
        pulse_reset();
        r0 = rsp_cnt;
        repeat (20) tick();
        chk("reset_flush_rsp", 32'(rsp_cnt), 32'(r0));
        for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op());
        tick();
        req_valid = '0;
        chk("reset_priority", 32'(grant_log[$]), 32'd0);

        // Sparse requests that wrap the pointer, back to back.
        set_req(3, rnd_op(), rnd_op());
        tick();
        req_valid = '0;
        set_req(0, rnd_op(), rnd_op());
        tick();
        req_valid = '0;
        chk("sparse_grant_3", 32'(grant_log[grant_log.size()-2]), 32'd3);
        chk("sparse_grant_0", 32'(grant_log[$]), 32'd0);
        repeat (LAT + 4) tick();

        // Randomized traffic with occasional drain windows and resets.
        drain_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            dens = (c < 500) ? 25 : 80;
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]      = ($urandom_range(0, 99) < dens);
                req_a[32*i +: 32] = rnd_op();
                req_b[32*i +: 32] = rnd_op();
            end
            if (drain_cnt > 0) drain_cnt--;
            else if ($urandom_range(0, 99) == 0) drain_cnt = $urandom_range(5, 30);
            drain = (drain_cnt > 0);
            reset = ($urandom_range(0, 599) != 0);
            tick();
        end
        reset     = 1'b1;
        drain     = 1'b0;
        req_valid = '0;
        repeat (LAT + 6) tick();
        chk("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
`ifdef FP_ADD_SCHED_STATS_EN
        chk("stat_issued", stat_issued, 32'(m_iss));
        chk("stat_conflict", stat_conflict, 32'(m_conf));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_add_sched.md
# fp_add_sched

Round-robin scheduler that shares one pipelined single-precision `FP_ADD` among `NREQ` requesters. It accepts at most one operand pair per cycle and drives the adder's `a`/`b` from registers. It tracks each in-flight operation's requester ID in a valid/tag shift register matched to the adder latency, then routes `q` back to the owning requester as a one-cycle response. It sits between the accumulation/reduction engines and the shared adder, replacing dedicated adder instances per engine.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 7: `FP_ADD` pipeline latency in cycles, edge of `a`/`b` to valid `q`; must match the instantiated adder.
- `IDW`, `$clog2(NREQ)`: requester-ID width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`.
- `req_valid` in NREQ: requester i has an operand pair.
- `req_a` in 32·NREQ: operand A, slice i = bits [32i+31:32i].
- `req_b` in 32·NREQ: operand B, same slicing.
- `req_ready` out NREQ: one-hot grant (combinational); transfer when `req_valid[i] && req_ready[i]`.
- `add_a` out 32: registered operand A to `FP_ADD.a`.
- `add_b` out 32: registered operand B to `FP_ADD.b`.
- `add_q` in 32: `FP_ADD.q`.
- `rsp_valid` out NREQ: one-hot, one-cycle response strobe.
- `rsp_data` out 32: registered sum, valid when any `rsp_valid` bit is set.
- `drain` in 1: level request to stop accepting and empty the pipeline.
- `idle` out 1: no operations in flight and state IDLE.

## Operation
- State machine: RUN, DRAIN, IDLE. Reset enters RUN.
  - RUN → DRAIN when `drain=1`.
  - DRAIN → IDLE when the shift register is empty and `drain=1`.
  - DRAIN or IDLE → RUN when `drain=0`.
- Grant is issued only in RUN; `req_ready` is all-zero in DRAIN and IDLE.
- Arbitration uses pointer `last` (IDW bits).
  - Priority order: `last+1, last+2, …` modulo NREQ.
  - The first asserted `req_valid` in that order receives `req_ready`.
  - `last` updates to the granted index only on transfer.
  - Reset value of `last` is NREQ-1, so requester 0 has first priority.
  - A requester with continuous `req_valid` is granted at most once per NREQ cycles while others contend.
- On transfer, register the granted `req_a`/`req_b` into `add_a`/`add_b`, and push `{1, id}` into shift register stage 0.
- With no transfer, `add_a`/`add_b` hold their previous value and stage 0 is pushed as `{0, x}`.
- Shift register has depth LAT+1 and advances every cycle; it never stalls.
- At the output stage, if valid:
  - register `add_q` into `rsp_data`;
  - set `rsp_valid[id]` for one cycle.
- With output stage invalid, `rsp_valid` = 0 and `rsp_data` holds.
- Responses have no back-pressure. Requesters must sink a response in the cycle it is presented.
- Results return in issue order.

## Timing
- Reset values: `req_ready` = 0 during reset, `add_a` = `add_b` = 0, `rsp_valid` = 0, `rsp_data` = 0, `idle` = 0, `last` = NREQ-1, all shift-register valid bits 0.
- Throughput: one transfer per cycle sustained.
- Latency: a transfer in cycle t produces `add_a`/`add_b` valid in cycle t+1, and `rsp_valid` in cycle t+LAT+2 for exactly one cycle.
- `drain` asserted in cycle t blocks grants from cycle t+1. A transfer in cycle t still completes.
- `idle` rises in the cycle after the last response; it falls the cycle after `drain` deasserts.
- Reset mid-operation clears all valid bits. Adder results in flight are discarded, and no `rsp_valid` appears for them after reset.
- Responses and new grants can occur in the same cycle, with no interaction.

## Configuration
- `FP_ADD_SCHED_STATS_EN` defined adds two outputs, both cleared by reset and saturating at all-ones:
  - `stat_issued` (32-bit): count of transfers;
  - `stat_conflict` (32-bit): cycles with two or more `req_valid` bits set in RUN.
- Without the macro, these ports and counters do not exist. Behaviour of all other ports is identical in both builds.

## Test plan
- Single op: NREQ=4, LAT=7. Requester 2 sends A=0x3F800000, B=0x40000000 in cycle 10 → `add_a`/`add_b` show the operands in cycle 11; `rsp_valid`=4'b0100 and `rsp_data`=0x40400000 in cycle 19 only.
- Fairness: all four `req_valid` held high for 8 cycles after reset → grants in order 0,1,2,3,0,1,2,3. Each requester gets 2 responses, tagged correctly, back-to-back.
- Drain: stream from requester 1 and assert `drain` in cycle t → no grant after t. `idle`=1 exactly one cycle after the final response. Deasserting `drain` → grant resumes in the next cycle.
- Reset mid-flight: issue 3 ops, pull `reset` low for 1 cycle two cycles later → no `rsp_valid` in the following 20 cycles, and `last` restores priority to requester 0.
- Sparse/pointer wrap: only requester 3 valid, then only requester 0 → each granted immediately, with no idle-cycle penalty.
- STATS build: 5 transfers with 2 contended cycles → `stat_issued`=5, `stat_conflict`=2.
